// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcode constants and FSM state type for alu_seq.
package alu_seq_pkg;
  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_XOR   = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_ORR   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_LSL   = 4'b1000;
  localparam logic [3:0] OP_LSR   = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_NOR   = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - iterative shift-add multiplier (alu_mul_iter), low DATA_WIDTH bits.
// Loads on start, runs DATA_WIDTH steps, then pulses done with the product held on product.
module alu_mul_iter #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] product
);
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_mcand;
  logic [DATA_WIDTH-1:0] r_mplier;
  logic [CW-1:0]         r_cnt;
  logic                  r_busy;
  logic                  r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_acc    <= '0;
        r_mcand  <= a;
        r_mplier <= b;
        r_cnt    <= '0;
        r_busy   <= 1'b1;
      end else if (r_busy) begin
        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CW'(1);
        // The counter reaches DATA_WIDTH on the final step, hence the extra bit.
        if (r_cnt == CW'(DATA_WIDTH - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign done    = r_done;
  assign product = r_acc;
endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked multi-cycle ALU with registered result and NZCV flags.
// ALU_SEQ_MUL_EN enables the iterative multiplier (opcode 1010) and the BUSY state.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int SEL_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_WIDTH-1:0]  select,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] F,
  output logic                  zero,
  output logic                  neg,
  output logic                  carry,
  output logic                  ovf,
  output logic                  err
);
  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int MSB = DATA_WIDTH - 1;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_a, r_b, r_f;
  logic [SEL_WIDTH-1:0]  r_sel;
  logic                  r_zero, r_neg, r_carry, r_ovf, r_err, r_out_valid;

  logic [DATA_WIDTH:0]   w_sum, w_diff;
  logic [SHW-1:0]        w_shamt;
  logic [DATA_WIDTH-1:0] w_res;
  logic                  w_c, w_v, w_ill;

  assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff  = {1'b0, r_a} - {1'b0, r_b};
  assign w_shamt = r_b[SHW-1:0];

  // Illegal opcodes leave w_res at zero, which directly yields F=0 and zero=1.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_ill = 1'b0;
    case (r_sel)
      SEL_WIDTH'(OP_AND):   w_res = r_a & r_b;
      SEL_WIDTH'(OP_XOR):   w_res = r_a ^ r_b;
      SEL_WIDTH'(OP_ORR):   w_res = r_a | r_b;
      SEL_WIDTH'(OP_NOR):   w_res = ~(r_a | r_b);
      SEL_WIDTH'(OP_PASSB): w_res = r_b;
      SEL_WIDTH'(OP_LSL):   w_res = r_a << w_shamt;
      SEL_WIDTH'(OP_LSR):   w_res = r_a >> w_shamt;
      SEL_WIDTH'(OP_ADD): begin
        w_res = w_sum[MSB:0];
        w_c   = w_sum[DATA_WIDTH];
        w_v   = (r_a[MSB] == r_b[MSB]) && (w_sum[MSB] != r_a[MSB]);
      end
      SEL_WIDTH'(OP_SUB): begin
        w_res = w_diff[MSB:0];
        w_c   = ~w_diff[DATA_WIDTH];
        w_v   = (r_a[MSB] != r_b[MSB]) && (w_diff[MSB] != r_a[MSB]);
      end
      default: w_ill = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  logic                  w_mul_start, w_mul_done;
  logic [DATA_WIDTH-1:0] w_prod;

  assign w_mul_start = in_valid && (r_state == ST_IDLE) && (select == SEL_WIDTH'(OP_MUL));

  alu_mul_iter #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (w_mul_start),
    .a       (A),
    .b       (B),
    .done    (w_mul_done),
    .product (w_prod)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sel       <= '0;
      r_f         <= '0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a   <= A;
            r_b   <= B;
            r_sel <= select;
`ifdef ALU_SEQ_MUL_EN
            if (select == SEL_WIDTH'(OP_MUL)) r_state <= ST_BUSY;
            else r_state <= ST_DONE;
`else
            r_state <= ST_DONE;
`endif
          end
        end
`ifdef ALU_SEQ_MUL_EN
        ST_BUSY: begin
          if (w_mul_done) begin
            r_f         <= w_prod;
            r_zero      <= (w_prod == '0);
            r_neg       <= w_prod[MSB];
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          // First DONE cycle after a single-cycle accept registers the result.
          if (!r_out_valid) begin
            r_f         <= w_res;
            r_zero      <= (w_res == '0);
            r_neg       <= w_res[MSB];
            r_carry     <= w_c;
            r_ovf       <= w_v;
            r_err       <= w_ill;
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = r_out_valid;
  assign F         = r_f;
  assign zero      = r_zero;
  assign neg       = r_neg;
  assign carry     = r_carry;
  assign ovf       = r_ovf;
  assign err       = r_err;
endmodule
